// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the shared add/sub ALU controller.
// The FSM state encoding and the ALU select codes live here.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;
    localparam int   ALU_W   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
// The grant is one-hot, or zero when no request is active.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered add/sub ALU between NUM_REQ requesters: round-robin
// grant, operand issue, wait for the ALU's one-cycle latency, tagged response.
//
// state | meaning
// IDLE  | ready to grant; req_ready follows the arbiter winner
// ISSUE | alu_* stable, the ALU captures them at the end of this cycle
// WAIT  | alu_res valid, captured into rsp_res/rsp_zero
// RESP  | rsp_valid held with stable payload until rsp_ready
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int DATA_W  = ALU_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_opa,
    input  logic [NUM_REQ*DATA_W-1:0] req_opb,
    input  logic [NUM_REQ-1:0]        req_sel,
    output logic [DATA_W-1:0]         alu_opa,
    output logic [DATA_W-1:0]         alu_opb,
    output logic                      alu_sel,
    input  logic [DATA_W-1:0]         alu_res,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_res,
    output logic                      rsp_zero,
    output logic                      busy
);

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      id_q;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      win_idx;
    logic [ID_W-1:0]      next_ptr;
    logic [DATA_W-1:0]    win_opa;
    logic [DATA_W-1:0]    win_opb;
    logic                 win_sel;
    logic                 accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    // Grant is a subset of req_valid, so ready never lands on an idle requester.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign rsp_id    = id_q;

    always_comb begin
        win_opa = '0;
        win_opb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_opa = req_opa[i*DATA_W +: DATA_W];
                win_opb = req_opb[i*DATA_W +: DATA_W];
            end
        end
        win_sel = |(grant & req_sel);
    end

    always_comb begin
        if (win_idx == ID_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            alu_opa   <= '0;
            alu_opb   <= '0;
            alu_sel   <= ALU_ADD;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_opa <= win_opa;
                        alu_opb <= win_opb;
                        alu_sel <= win_sel ? ALU_SUB : ALU_ADD;
                        id_q    <= win_idx;
                        ptr     <= next_ptr;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    rsp_res   <= alu_res;
                    rsp_zero  <= (alu_res == '0);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a registered add/sub ALU model and
// a scoreboard of expected responses pushed at each accepted request.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int DW      = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_opa;
    logic [NUM_REQ*DW-1:0] req_opb;
    logic [NUM_REQ-1:0]    req_sel;
    logic [DW-1:0]         alu_opa;
    logic [DW-1:0]         alu_opb;
    logic                  alu_sel;
    logic [DW-1:0]         alu_res = '0;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [DW-1:0]         rsp_res;
    logic                  rsp_zero;
    logic                  busy;

    alu_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opa   (req_opa),
        .req_opb   (req_opb),
        .req_sel   (req_sel),
        .alu_opa   (alu_opa),
        .alu_opb   (alu_opb),
        .alu_sel   (alu_sel),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External ALU: one-cycle registered add/sub.
    always @(posedge clk) begin
        alu_res <= (alu_sel == ALU_SUB) ? (alu_opa - alu_opb) : (alu_opa + alu_opb);
    end

    typedef struct {
        logic [ID_W-1:0] id;
        logic [DW-1:0]   res;
        logic            zero;
        int              acc_cycle;
    } exp_t;

    exp_t            sb[$];
    exp_t            exp_pend[NUM_REQ];
    int              grant_log[$];
    int              acc_cycles[$];
    int              acc_cnt[NUM_REQ];
    bit              acc_flag[NUM_REQ];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              n_rsp   = 0;
    int              cycle   = 0;
    logic            p_valid = 1'b0;
    logic            p_ready = 1'b0;
    logic [ID_W-1:0] p_id    = '0;
    logic [DW-1:0]   p_res   = '0;
    logic            p_zero  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (rst) begin
            sb.delete();
            p_valid = 1'b0;
            return;
        end
        chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e           = exp_pend[i];
                e.acc_cycle = cycle;
                sb.push_back(e);
                acc_flag[i] = 1'b1;
                acc_cnt[i]++;
                grant_log.push_back(i);
                acc_cycles.push_back(cycle);
            end
        end
        if (rsp_valid && !p_valid) begin
            if (sb.size() == 0) chk("rsp_spurious", 32'd1, 32'd0);
            else chk("latency", 32'(cycle - sb[0].acc_cycle), 32'd3);
        end
        if (rsp_valid && p_valid && !p_ready) begin
            chk("bp_hold_id", 32'(rsp_id), 32'(p_id));
            chk("bp_hold_res", 32'(rsp_res), 32'(p_res));
            chk("bp_hold_zero", 32'(rsp_zero), 32'(p_zero));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_res", 32'(rsp_res), 32'(e.res));
                chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            end
            n_rsp++;
        end
        p_valid = rsp_valid;
        p_ready = rsp_ready;
        p_id    = rsp_id;
        p_res   = rsp_res;
        p_zero  = rsp_zero;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic sel, input logic [DW-1:0] res);
        req_opa[id*DW +: DW] = a;
        req_opb[id*DW +: DW] = b;
        req_sel[id]          = sel;
        exp_pend[id].id      = ID_W'(id);
        exp_pend[id].res     = res;
        exp_pend[id].zero    = (res == '0);
    endtask

    task automatic do_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic sel, input logic [DW-1:0] res);
        set_req(id, a, b, sel, res);
        acc_flag[id]  = 1'b0;
        req_valid[id] = 1'b1;
        for (int t = 0; t < 20 && !acc_flag[id]; t++) tick();
        if (!acc_flag[id]) chk("accept_timeout", 32'd0, 32'd1);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 40 && (sb.size() != 0 || rsp_valid || busy); t++) tick();
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_alu_opa"}, 32'(alu_opa), 32'd0);
        chk({tag, "_alu_opb"}, 32'(alu_opb), 32'd0);
        chk({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_res"}, 32'(rsp_res), 32'd0);
        chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int a1;
        int rsp_before;

        rst       = 1'b1;
        req_valid = '0;
        req_opa   = '0;
        req_opb   = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_cnt[i]  = 0;
            acc_flag[i] = 1'b0;
        end
        tick();
        tick();
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // Single op and wrap/zero cases
        do_op(0, 8'h05, 8'h03, ALU_ADD, 8'h08);
        wait_idle();
        do_op(0, 8'hFF, 8'h01, ALU_ADD, 8'h00);
        wait_idle();
        do_op(0, 8'h00, 8'h01, ALU_SUB, 8'hFF);
        wait_idle();
        // Requester 1 once, which also returns the pointer to 0
        do_op(1, 8'h10, 8'h20, ALU_SUB, 8'hF0);
        wait_idle();

        // Round-robin with both requesters held valid
        set_req(0, 8'h0A, 8'h01, ALU_ADD, 8'h0B);
        set_req(1, 8'h50, 8'h60, ALU_SUB, 8'hF0);
        base      = grant_log.size();
        req_valid = 2'b11;
        for (int t = 0; t < 40 && grant_log.size() < base + 4; t++) tick();
        req_valid = 2'b00;
        chk("rr_accepts", 32'(grant_log.size() - base), 32'd4);
        if (grant_log.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) chk("rr_order", 32'(grant_log[base + k]), 32'(k % 2));
            for (int k = 1; k < 4; k++)
                chk("rr_spacing", 32'(acc_cycles[base + k] - acc_cycles[base + k - 1]), 32'd4);
        end
        wait_idle();

        // Backpressure with requester 1 waiting
        rsp_ready = 1'b0;
        do_op(0, 8'h40, 8'h02, ALU_SUB, 8'h3E);
        for (int t = 0; t < 10 && !rsp_valid; t++) tick();
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        set_req(1, 8'h09, 8'h01, ALU_ADD, 8'h0A);
        acc_flag[1]  = 1'b0;
        req_valid[1] = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        chk("bp_still_valid", 32'(rsp_valid), 32'd1);
        chk("bp_no_accept", 32'(acc_flag[1]), 32'd0);
        rsp_ready = 1'b1;
        for (int t = 0; t < 10 && !acc_flag[1]; t++) tick();
        req_valid[1] = 1'b0;
        chk("bp_req1_served", 32'(acc_flag[1]), 32'd1);
        wait_idle();

        // Reset while in WAIT
        do_op(0, 8'h11, 8'h22, ALU_ADD, 8'h33);
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_alu_opa", 32'(alu_opa), 32'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero_outputs("rst_mid");
        rsp_before = n_rsp;
        for (int t = 0; t < 8; t++) tick();
        chk("rst_no_rsp", 32'(n_rsp), 32'(rsp_before));
        do_op(0, 8'h07, 8'h07, ALU_SUB, 8'h00);
        wait_idle();

        // Requester 1 pulses valid while busy and withdraws before IDLE
        a1 = acc_cnt[1];
        do_op(0, 8'h30, 8'h03, ALU_ADD, 8'h33);
        set_req(1, 8'h01, 8'h01, ALU_ADD, 8'h02);
        req_valid[1] = 1'b1;
        tick();
        tick();
        req_valid[1] = 1'b0;
        wait_idle();
        for (int t = 0; t < 4; t++) tick();
        chk("withdrawn_not_granted", 32'(acc_cnt[1]), 32'(a1));

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("rsp_total", 32'(n_rsp), 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
